// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: FSM state
// encoding, slice width and the pass-count helper.
package nibble_add_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slice passes needed to cover a WIDTH-bit operand.
  function automatic int unsigned calc_nibs(input int unsigned width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_serial_add_seq.sv
// Multi-cycle sequencer around an external 4-bit carry-in adder slice.
// Operands arrive over in_valid/in_ready, are fed to the slice one nibble
// per cycle LSB first with the carry looped back, and the WIDTH+1-bit
// result {carry, sum} leaves over out_valid/out_ready.
// Optional build macro NIBBLE_SUB_EN adds port op_sub: when set on accept
// the block computes A-B (result[WIDTH]=1 means no borrow).
module nibble_serial_add_seq
  import nibble_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
`ifdef NIBBLE_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic [3:0]       add_k,
  output logic [3:0]       add_t,
  output logic             add_cin,
  input  logic [4:0]       add_s
);

  localparam int unsigned NIBS  = calc_nibs(WIDTH);
  localparam int unsigned IDX_W = $clog2(NIBS);

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_a_sh;
  logic [WIDTH-1:0]     r_b_sh;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH:0]       r_result;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_carry;

  logic [WIDTH-1:0]     w_b_load;
  logic                 w_cin_load;
  logic [WIDTH-1:0]     w_acc_next;
  logic                 w_run;

  // Operand B and initial carry as loaded on accept.
`ifdef NIBBLE_SUB_EN
  assign w_b_load   = op_sub ? ~op_b : op_b;
  assign w_cin_load = op_sub | op_cin;
`else
  assign w_b_load   = op_b;
  assign w_cin_load = op_cin;
`endif

  // Accumulator with the current slice sum merged into nibble idx.
  always_comb begin
    w_acc_next = r_acc;
    for (int unsigned n = 0; n < NIBS; n++) begin
      if (r_idx == IDX_W'(n)) begin
        w_acc_next[n*NIB_W +: NIB_W] = add_s[NIB_W-1:0];
      end
    end
  end

  // Sequencer FSM: accept, NIBS slice passes, then hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh     <= op_a;
            r_b_sh     <= w_b_load;
            r_carry    <= w_cin_load;
            r_idx      <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= add_s[NIB_W];
          r_a_sh  <= r_a_sh >> NIB_W;
          r_b_sh  <= r_b_sh >> NIB_W;
          if (r_idx == IDX_W'(NIBS - 1)) begin
            // Result is captured straight from the final slice output so it
            // is valid on the first DONE cycle without an extra stage.
            r_result    <= {add_s[NIB_W], w_acc_next};
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign w_run     = (r_state == RUN);
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign add_k     = w_run ? r_a_sh[NIB_W-1:0] : '0;
  assign add_t     = w_run ? r_b_sh[NIB_W-1:0] : '0;
  assign add_cin   = w_run & r_carry;

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Self-checking bench for nibble_serial_add_seq with a behavioural 4-bit
// slice and an arithmetic reference model.
module tb_nibble_serial_add_seq;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
`ifdef NIBBLE_SUB_EN
  logic         op_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   result;
  logic [3:0]   add_k;
  logic [3:0]   add_t;
  logic         add_cin;
  logic [4:0]   add_s;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc = -1;

  always #5 clk = ~clk;

  // Behavioural slice: s = k + t + cin.
  assign add_s = 5'(add_k) + 5'(add_t) + 5'(add_cin);

  nibble_serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
`ifdef NIBBLE_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .add_k     (add_k),
    .add_t     (add_t),
    .add_cin   (add_cin),
    .add_s     (add_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One full operation with optional output stall; b2b keeps in_valid and
  // out_ready high and checks the accept spacing.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       input int stall, input bit b2b);
    logic [31:0] bb, c0, exp, mask, cexp;
    int waited;
    bb  = sub ? {16'h0, ~b} : {16'h0, b};
    c0  = sub ? 32'd1 : {31'd0, cin};
    exp = {16'h0, a} + bb + c0;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check_eq("in_ready_idle", {31'd0, in_ready}, 32'd1);
    op_a = a;
    op_b = b;
    op_cin = cin;
`ifdef NIBBLE_SUB_EN
    op_sub = sub;
`endif
    in_valid = 1'b1;
    if (b2b && last_acc >= 0) check_eq("accept_spacing", cyc - last_acc, 32'd6);
    last_acc = cyc;
    tick();
    if (!b2b) in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      mask = (32'd1 << (4 * i)) - 32'd1;
      cexp = (({16'h0, a} & mask) + (bb & mask) + c0) >> (4 * i);
      if (i == 0) check_eq("result_cleared", {15'd0, result}, 32'd0);
      check_eq("add_k", {28'd0, add_k}, ({16'h0, a} >> (4 * i)) & 32'hF);
      check_eq("add_t", {28'd0, add_t}, (bb >> (4 * i)) & 32'hF);
      check_eq("add_cin", {31'd0, add_cin}, cexp);
      check_eq("in_ready_run", {31'd0, in_ready}, 32'd0);
      check_eq("out_valid_run", {31'd0, out_valid}, 32'd0);
      tick();
    end
    check_eq("out_valid_done", {31'd0, out_valid}, 32'd1);
    check_eq("result", {15'd0, result}, exp);
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      op_a = W'($urandom);
      op_b = W'($urandom);
      tick();
      check_eq("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stall_result", {15'd0, result}, exp);
      check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = b2b;
    out_ready = 1'b1;
    tick();
    if (!b2b) out_ready = 1'b0;
    check_eq("idle_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("idle_result_held", {15'd0, result}, exp);
    check_eq("idle_add_k", {28'd0, add_k}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    op_cin = 1'b0;
`ifdef NIBBLE_SUB_EN
    op_sub = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_result", {15'd0, result}, 32'd0);
    check_eq("rst_add_k", {28'd0, add_k}, 32'd0);
    check_eq("rst_add_t", {28'd0, add_t}, 32'd0);
    check_eq("rst_add_cin", {31'd0, add_cin}, 32'd0);

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 0, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 3, 1'b0);

    // Reset pulsed during the second RUN cycle.
    op_a = 16'hABCD;
    op_b = 16'h1111;
    op_cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_add_k", {28'd0, add_k}, 32'd0);
    check_eq("midrst_add_t", {28'd0, add_t}, 32'd0);
    check_eq("midrst_result", {15'd0, result}, 32'd0);
    do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0, 1'b0);

    // Back-to-back random operations.
    last_acc  = -1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 0, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();

`ifdef NIBBLE_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 0, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_seq.md
Name: nibble_serial_add_seq

Overview:
- Multi-cycle sequencer wrapped around the 4-bit carry-in adder slice (ksadd4b-class: k[3:0], t[3:0], cin -> s[4:0]).
- Accepts WIDTH-bit operand pairs over a valid/ready handshake and feeds the slice one nibble per cycle, LSB first.
- Captures each 4-bit sum, loops carry-out back to carry-in, and returns a WIDTH+1-bit result over a second valid/ready handshake.
- Sits directly upstream of the slice (drives its operands) and downstream of it (consumes its sum). The slice itself is external.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and >= 8.
- NIBS, WIDTH/4, derived; number of slice passes per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept an operand pair.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- op_cin  input  1  carry-in for the whole operation.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH+1  {carry_out, sum}.
- add_k  output  4  nibble of A to slice input K.
- add_t  output  4  nibble of B to slice input T.
- add_cin  output  1  carry into slice.
- add_s  input  5  slice output {s4..s0}; s4 is the carry out. Combinational, valid in the same cycle.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- States and transitions:
  - IDLE -> RUN on in_valid && in_ready.
  - RUN stays in RUN while idx < NIBS-1.
  - RUN -> DONE when idx == NIBS-1.
  - DONE -> IDLE on out_ready.
- Values after reset: state=IDLE, in_ready=1, out_valid=0, result=0, add_k=0, add_t=0, add_cin=0, idx=0, carry=0.
- Accept (IDLE, in_valid && in_ready): latch op_a and op_b into shift registers, carry <= op_cin, idx <= 0, clear the result accumulator.
- in_ready = (state == IDLE). in_valid is ignored in RUN and DONE. No queuing.
- RUN outputs: add_k = a_sh[3:0], add_t = b_sh[3:0], add_cin = carry. In IDLE and DONE all three are 0.
- RUN, each cycle:
  - acc nibble[idx] <= add_s[3:0] and carry <= add_s[4].
  - a_sh and b_sh shift right by 4.
  - idx <= idx + 1.
- DONE: result = {carry, acc}, out_valid = 1. result is held stable until the handshake.
- Latency: accept in cycle 0; RUN occupies cycles 1..NIBS; out_valid is high from cycle NIBS+1. With WIDTH=16, out_valid asserts in cycle 5.
- Back-to-back throughput: if out_ready is high on the first DONE cycle, the next operand is accepted one cycle later in IDLE. Initiation interval is NIBS+2 cycles.
- Width rules:
  - Sum is modulo 2^WIDTH; result[WIDTH] is the final carry.
  - idx width is clog2(NIBS); it does not wrap during a legal operation.
- Output hold: result is held from DONE until the next accept, then cleared on the accept edge. In IDLE, result shows the last value; consumers qualify it with out_valid.
- Reset mid-operation (RUN or DONE): the operation is abandoned, all registers return to reset values, and no out_valid is produced.
- out_ready while not in DONE: ignored.

Optional Feature:
- Macro: NIBBLE_SUB_EN.
- Defined:
  - Adds input port op_sub (1 bit), latched on accept.
  - When op_sub=1: b_sh is loaded with ~op_b and carry with 1 (op_cin ignored), giving A-B.
  - result[WIDTH] = 1 means no borrow.
- Undefined: op_sub port does not exist; addition only.

Decomposition:
- Shared package nibble_add_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - NIB_W=4;
  - the function computing NIBS from WIDTH.
- No sub-module inside the block. The slice stays external so gate-level cmos slices can be swapped in.
- The bench provides a behavioural 4-bit adder model, add_s = k + t + cin.

Test Plan:
- Carry across all nibbles: rst for 2 cycles, then op_a=16'hFFFF, op_b=16'h0001, op_cin=0 -> out_valid in cycle 5 with result=17'h10000; add_cin seen as 0,1,1,1 over the RUN cycles.
- Carry-in only: op_a=16'h1234, op_b=16'h4321, op_cin=1 -> result=17'h05556; in_ready low in cycles 1..5.
- Output backpressure: op_a=16'h8000, op_b=16'h8000, out_ready held 0 for 3 cycles -> result=17'h10000 stable with out_valid high throughout; in_valid pulsed during DONE is not accepted.
- Reset mid-operation: rst pulsed in RUN cycle 2 -> next cycle in_ready=1, out_valid=0, add_k=add_t=0; a following op 16'h0003+16'h0004 returns 17'h00007.
- Back-to-back operations: 10 random operand pairs with out_ready=1 and in_valid always high -> each result matches a+b+cin; accepts are spaced exactly 6 cycles apart.
- Subtraction (NIBBLE_SUB_EN defined): op_a=16'h0005, op_b=16'h0007, op_sub=1 -> result=17'h0FFFE (borrow, bit16=0); with op_a=16'h0007, op_b=16'h0005 -> 17'h10002.
